// File: rtl/pps_frequency_counter_pkg.sv
// Shared definitions for the PPS frequency counter: FSM states, default
// widths and the layout of the status flags in the SPI MISO counter word.
package pps_frequency_counter_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 35;
    localparam int DEFAULT_GATE_WIDTH  = 4;
    localparam int MIN_SYNC_STAGES     = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // MISO word = {result, flags}; flag bit positions within the flag field
    localparam int SPI_FLAG_VALID     = 0;
    localparam int SPI_FLAG_SATURATED = 1;
    localparam int SPI_FLAG_OVERRUN   = 2;
    localparam int SPI_FLAG_GLITCH    = 3;
    localparam int SPI_FLAG_MISSING   = 4;
    localparam int SPI_FLAG_BITS      = 5;
    localparam int SPI_RESULT_LSB     = SPI_FLAG_BITS;

    // Packs the status outputs into the flag field of the MISO word
    function automatic logic [SPI_FLAG_BITS-1:0] pack_flags(
        input logic valid,
        input logic saturated,
        input logic overrun,
        input logic glitch,
        input logic missing
    );
        logic [SPI_FLAG_BITS-1:0] flags;
        flags                     = '0;
        flags[SPI_FLAG_VALID]     = valid;
        flags[SPI_FLAG_SATURATED] = saturated;
        flags[SPI_FLAG_OVERRUN]   = overrun;
        flags[SPI_FLAG_GLITCH]    = glitch;
        flags[SPI_FLAG_MISSING]   = missing;
        return flags;
    endfunction

endpackage

// File: rtl/pps_frequency_counter_edge_detect.sv
// Synchroniser for the asynchronous PPS pin followed by a history flop;
// pps_rise is high for one cycle, SYNC_STAGES+1 cycles after the pin rises
// (the clock edge that sees it is that many edges after the pin change).
module pps_edge_detect
    import pps_frequency_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pps_in,
    output logic pps_rise
);

    // Never build fewer than two synchroniser flops
    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_reg;
    logic              hist_reg;

    // Shift the pin through the synchroniser chain and keep one history bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], pps_in};
            hist_reg <= sync_reg[STAGES-1];
        end
    end

    assign pps_rise = sync_reg[STAGES-1] & ~hist_reg;

endmodule

// File: rtl/pps_frequency_counter.sv
// Counts reference-clock cycles across a window of (gate_count+1) PPS
// intervals, with glitch rejection, lost-PPS timeout, counter saturation
// and an overrun flag for results overwritten before the host read them.
module pps_frequency_counter
    import pps_frequency_counter_pkg::*;
#(
    parameter int          COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int          GATE_WIDTH  = DEFAULT_GATE_WIDTH,
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_PERIOD  = 1024,
    parameter logic [63:0] TIMEOUT     = (64'd1 << COUNT_WIDTH) - 64'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pps_in,
    input  logic [GATE_WIDTH-1:0]  gate_count,
    input  logic                   ack,
    output logic [COUNT_WIDTH-1:0] result,
    output logic                   result_valid,
    output logic                   result_saturated,
    output logic                   result_overrun,
    output logic                   pps_glitch,
    output logic                   pps_missing,
    output logic                   pps_strobe
);

    // since_edge must be able to reach TIMEOUT even when the result
    // counter is narrower than the timeout
    localparam int TIMEOUT_BITS = $clog2(TIMEOUT + 64'd1);
    localparam int SINCE_WIDTH  = (TIMEOUT_BITS > COUNT_WIDTH) ? TIMEOUT_BITS : COUNT_WIDTH;
    localparam logic [SINCE_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT[SINCE_WIDTH-1:0];
    localparam logic [SINCE_WIDTH-1:0] MIN_LIMIT     = SINCE_WIDTH'(MIN_PERIOD - 1);

    state_t                 state_reg;
    state_t                 state_next;

    logic                   pps_rise;
    logic                   edge_accept;
    logic                   edge_reject;
    logic                   window_done;
    logic                   window_start;
    logic                   timeout_hit;

    logic [SINCE_WIDTH-1:0] since_edge_reg;
    logic [COUNT_WIDTH-1:0] counter_reg;
    logic                   sat_reg;
    logic [GATE_WIDTH-1:0]  intervals_reg;
    logic [GATE_WIDTH-1:0]  gate_reg;

    logic [COUNT_WIDTH-1:0] result_reg;
    logic                   result_valid_reg;
    logic                   result_saturated_reg;
    logic                   result_overrun_reg;
    logic                   pps_glitch_reg;
    logic                   pps_missing_reg;
    logic                   pps_strobe_reg;

    pps_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_detect (
        .clk      (clk),
        .rst      (rst),
        .pps_in   (pps_in),
        .pps_rise (pps_rise)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Edge qualification, window completion, timeout and next state
    always_comb begin
        state_next  = state_reg;
        edge_accept = 1'b0;
        edge_reject = 1'b0;
        window_done = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                // first edge starts a window without a spacing check
                if (pps_rise) begin
                    edge_accept = 1'b1;
                    state_next  = MEASURE;
                end
            end
            MEASURE: begin
                if (pps_rise) begin
                    if (since_edge_reg < MIN_LIMIT) begin
                        edge_reject = 1'b1;
                    end else begin
                        edge_accept = 1'b1;
                        window_done = (intervals_reg == gate_reg);
                    end
                end
                // an accepted edge on the timeout cycle keeps the window alive
                if (!edge_accept && since_edge_reg == TIMEOUT_LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign window_start = (state_reg == IDLE && edge_accept) || window_done;

    // Cycles since the last accepted edge, saturating; held at zero in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            since_edge_reg <= '0;
            pps_strobe_reg <= 1'b0;
        end else begin
            pps_strobe_reg <= edge_accept;
            if (state_reg == IDLE || edge_accept) begin
                since_edge_reg <= '0;
            end else if (since_edge_reg != '1) begin
                since_edge_reg <= since_edge_reg + 1'b1;
            end
        end
    end

    // Window counter: restarts at 1 on the window edge so no cycle is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg   <= '0;
            sat_reg       <= 1'b0;
            intervals_reg <= '0;
            gate_reg      <= '0;
        end else if (window_start) begin
            counter_reg   <= COUNT_WIDTH'(1);
            sat_reg       <= 1'b0;
            intervals_reg <= '0;
            gate_reg      <= gate_count;
        end else if (timeout_hit) begin
            counter_reg   <= '0;
            sat_reg       <= 1'b0;
            intervals_reg <= '0;
        end else if (state_reg == MEASURE) begin
            if (counter_reg == '1) begin
                sat_reg <= 1'b1;
            end else begin
                counter_reg <= counter_reg + 1'b1;
            end
            if (edge_accept) begin
                intervals_reg <= intervals_reg + 1'b1;
            end
        end
    end

    // Latched result; a new result takes priority over the host ack
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg           <= '0;
            result_valid_reg     <= 1'b0;
            result_saturated_reg <= 1'b0;
        end else if (window_done) begin
            result_reg           <= counter_reg;
            result_valid_reg     <= 1'b1;
            result_saturated_reg <= sat_reg;
        end else if (ack) begin
            result_reg           <= '0;
            result_valid_reg     <= 1'b0;
            result_saturated_reg <= 1'b0;
        end
    end

    // Sticky status flags; a flag raised this cycle beats a clearing ack
    always_ff @(posedge clk) begin
        if (rst) begin
            result_overrun_reg <= 1'b0;
            pps_glitch_reg     <= 1'b0;
            pps_missing_reg    <= 1'b0;
        end else begin
            if (window_done && result_valid_reg && !ack) begin
                result_overrun_reg <= 1'b1;
            end else if (ack) begin
                result_overrun_reg <= 1'b0;
            end

            if (edge_reject) begin
                pps_glitch_reg <= 1'b1;
            end else if (ack) begin
                pps_glitch_reg <= 1'b0;
            end

            if (timeout_hit) begin
                pps_missing_reg <= 1'b1;
            end else if (ack) begin
                pps_missing_reg <= 1'b0;
            end
        end
    end

    assign result           = result_reg;
    assign result_valid     = result_valid_reg;
    assign result_saturated = result_saturated_reg;
    assign result_overrun   = result_overrun_reg;
    assign pps_glitch       = pps_glitch_reg;
    assign pps_missing      = pps_missing_reg;
    assign pps_strobe       = pps_strobe_reg;

endmodule

// File: doc/pps_frequency_counter.md
Name: pps_frequency_counter

Overview:
- Measures reference-clock cycles between GPS PPS edges over a programmable multi-second gate window.
- Sits between the PPS input pin and the SPI slave. Its latched result and status flags form the MISO counter word; the host acknowledges each read.
- Adds glitch rejection, missing-pulse timeout, saturation and overrun flags.

Parameters:
COUNT_WIDTH, 35, width of cycle counter and result
GATE_WIDTH, 4, width of gate_count
SYNC_STAGES, 2, synchroniser flops on pps_in (min 2)
MIN_PERIOD, 1024, min clk cycles between accepted edges; closer edges are glitches
TIMEOUT, 2**COUNT_WIDTH-1, clk cycles without an accepted edge before declaring PPS lost

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pps_in  in  1  asynchronous GPS pulse
gate_count  in  GATE_WIDTH  window length minus one, in PPS intervals
ack  in  1  one-cycle host read acknowledge
result  out  COUNT_WIDTH  latched cycle count of last window
result_valid  out  1  result holds an unread measurement
result_saturated  out  1  counter saturated during latched window
result_overrun  out  1  sticky: a result was overwritten while unread
pps_glitch  out  1  sticky: an edge was rejected by MIN_PERIOD
pps_missing  out  1  sticky: TIMEOUT expired
pps_strobe  out  1  one-cycle pulse per accepted edge

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, synchroniser cleared, counters 0, state IDLE. Reset mid-window discards the window.
- Edge detect:
  - pps_in passes SYNC_STAGES flops, then one history flop.
  - A rising edge is qualified SYNC_STAGES+1 cycles after the pin rises.
- Acceptance:
  - since_edge counts cycles from the last accepted edge, saturating. It is ignored in IDLE.
  - In MEASURE, a qualified edge with since_edge < MIN_PERIOD-1 is rejected: pps_glitch<=1, no other effect.
  - Otherwise the edge is accepted: pps_strobe=1 that cycle, since_edge<=0.
- States:
  - IDLE: first qualified edge is accepted unconditionally (no MIN_PERIOD check) -> MEASURE. counter<=1, intervals<=0, gate<=gate_count.
  - MEASURE, accepted edge with intervals!=gate: intervals<=intervals+1, counter increments normally.
  - MEASURE, accepted edge with intervals==gate:
    - result<=counter, result_saturated<=sat, result_valid<=1.
    - If result_valid was already 1 and ack is not asserted this cycle, result_overrun<=1.
    - New window starts the same cycle: counter<=1, sat<=0, intervals<=0, gate<=gate_count. No dead time; the edge cycle counts in the next window.
  - MEASURE, since_edge reaches TIMEOUT: pps_missing<=1, -> IDLE, partial window discarded, result untouched.
- Counter: +1 per cycle in MEASURE. At all-ones it holds and sets sat. With edges at cycles t0 and t1 (gate=0), result=t1-t0.
- gate_count is sampled only at window start; mid-window changes take effect next window.
- ack: result_valid<=0, result<=0, result_saturated<=0, result_overrun<=0, pps_glitch<=0, pps_missing<=0.
- Simultaneous ack and new result: new result wins (valid=1, new value); the flags set that cycle win over clearing.
- ack while valid=0: clears the flags only, harmless.
- Simultaneous timeout and accepted edge: the edge wins.

Decomposition:
- Shared package: state enum (IDLE, MEASURE), COUNT_WIDTH/GATE_WIDTH defaults, SPI word layout constants (flag bit positions).
- Sub-module pps_edge_detect (synchroniser + rising-edge strobe, parameter SYNC_STAGES). Everything else lives in one module.

Test Plan:
- MIN_PERIOD=8, TIMEOUT=200, gate_count=0. Edges at pin cycles 10, 110, 210 -> result=100 valid after the 2nd edge; after the 3rd, overrun=1 and result=100.
- gate_count=2, edges every 50 cycles -> one result=150 per 3 intervals. Change gate_count to 0 mid-window -> current window still 150, next window 50.
- Extra edge 4 cycles after an accepted edge -> pps_glitch=1, result unaffected (still 100 for 100-cycle spacing).
- No edge for 200 cycles in MEASURE -> pps_missing=1, state IDLE. Next edge restarts, first result only after a further full window.
- COUNT_WIDTH=6, edges 100 cycles apart -> result=63, result_saturated=1. ack on the result-latch cycle -> valid stays 1, new value kept.
- rst asserted mid-window -> all outputs 0 next cycle; no result until two edges after release.
